// File: rtl/branch_pkg.sv
// Shared types for the branch resolver: condition codes, flag indices, FSM states.
package branch_pkg;

    localparam int FLAG_V = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef enum logic [2:0] {
        COND_B   = 3'b000,
        COND_BEQ = 3'b001,
        COND_BNE = 3'b010,
        COND_BLT = 3'b011,
        COND_BLE = 3'b100
    } cond_e;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HAZARD   = 2'd1,
        S_RESOLVE  = 2'd2,
        S_REDIRECT = 2'd3
    } state_e;

endpackage

// File: rtl/branch_resolver_if.sv
// Branch request and redirect handshake bundle between requester/PC unit and resolver.
interface branch_resolver_if #(
    parameter int PC_W  = 9,
    parameter int OFF_W = 8
) ();

    logic             br_valid;
    logic             br_ready;
    logic [2:0]       br_cond;
    logic [OFF_W-1:0] br_off;
    logic [PC_W-1:0]  pc_in;
    logic             redirect_valid;
    logic             redirect_ready;
    logic [PC_W-1:0]  redirect_pc;
    logic             taken;
    logic             illegal;

    modport master (
        output br_valid, br_cond, br_off, pc_in, redirect_ready,
        input  br_ready, redirect_valid, redirect_pc, taken, illegal
    );

    modport slave (
        input  br_valid, br_cond, br_off, pc_in, redirect_ready,
        output br_ready, redirect_valid, redirect_pc, taken, illegal
    );

endinterface

// File: rtl/branch_resolver_cond_eval.sv
// Combinational condition evaluator: condition code and {V,N,Z} -> taken/illegal.
module cond_eval
    import branch_pkg::*;
(
    input  logic [2:0] i_cond,
    input  logic [2:0] i_flags,
    output logic       o_taken,
    output logic       o_illegal
);

    logic w_v;
    logic w_n;
    logic w_z;
    logic w_lt;

    assign w_v  = i_flags[FLAG_V];
    assign w_n  = i_flags[FLAG_N];
    assign w_z  = i_flags[FLAG_Z];
    assign w_lt = w_n ^ w_v;

    always_comb begin
        o_taken   = 1'b0;
        o_illegal = 1'b0;
        unique case (1'b1)
            (i_cond == COND_B):   o_taken = 1'b1;
            (i_cond == COND_BEQ): o_taken = w_z;
            (i_cond == COND_BNE): o_taken = ~w_z;
            (i_cond == COND_BLT): o_taken = w_lt;
            (i_cond == COND_BLE): o_taken = w_lt | w_z;
            default:              o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Status register plus conditional-branch resolver issuing PC redirects.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int PC_W  = 9,
    parameter int OFF_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        status_in,
    input  logic              load_s,
    output logic [2:0]        status_q,
    branch_resolver_if.slave  bus
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [2:0]       r_status;
    logic [2:0]       r_cond;
    logic [OFF_W-1:0] r_off;
    logic [PC_W-1:0]  r_pc;
    logic [PC_W-1:0]  r_redirect_pc;
    logic             r_taken;
    logic             r_illegal;

    logic             w_accept;
    logic             w_taken;
    logic             w_illegal;
    logic [PC_W-1:0]  w_pc_seq;
    logic [PC_W-1:0]  w_off_ext;
    logic [PC_W-1:0]  w_target;

    assign w_accept = (r_state == S_IDLE) && bus.br_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A flag write coinciding with accept costs one bubble before evaluation.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.br_valid) begin
                    w_state_nxt = load_s ? S_HAZARD : S_RESOLVE;
                end
            end
            S_HAZARD:  w_state_nxt = S_RESOLVE;
            S_RESOLVE: w_state_nxt = S_REDIRECT;
            S_REDIRECT: begin
                if (bus.redirect_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_status <= 3'b000;
        end else if (load_s) begin
            r_status <= status_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cond <= 3'b000;
            r_off  <= '0;
            r_pc   <= '0;
        end else if (w_accept) begin
            r_cond <= bus.br_cond;
            r_off  <= bus.br_off;
            r_pc   <= bus.pc_in;
        end
    end

    cond_eval u_cond_eval (
        .i_cond    (r_cond),
        .i_flags   (r_status),
        .o_taken   (w_taken),
        .o_illegal (w_illegal)
    );

    assign w_pc_seq  = r_pc + PC_W'(1);
    assign w_off_ext = {{(PC_W-OFF_W){r_off[OFF_W-1]}}, r_off};
    assign w_target  = w_pc_seq + w_off_ext;

    // Results are only written in RESOLVE, so they hold through REDIRECT and after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_redirect_pc <= '0;
            r_taken       <= 1'b0;
            r_illegal     <= 1'b0;
        end else if (r_state == S_RESOLVE) begin
            r_redirect_pc <= w_taken ? w_target : w_pc_seq;
            r_taken       <= w_taken;
            r_illegal     <= w_illegal;
        end
    end

    assign status_q           = r_status;
    assign bus.br_ready       = (r_state == S_IDLE);
    assign bus.redirect_valid = (r_state == S_REDIRECT);
    assign bus.redirect_pc    = r_redirect_pc;
    assign bus.taken          = r_taken;
    assign bus.illegal        = r_illegal;

endmodule
